adc_deser: RTL and testbench

ADC_DESER -- requirements
Module: adc_deser

---
 rtl/adc_deser.sv | 173 +++++++++++++++++
 tb/tb_adc_deser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_deser.sv
// adc_deser
//   Reads TOTAL_ADCS serial ADCs in parallel. They share one chip select and one
//   serial clock. Each readout takes FE_CLOCK_CYCLES samples from every ADC.
//   A sample period is one conversion cycle (CONV), then ADC_DATA_WIDTH SCLK
//   periods of MSB-first shifting (SHIFT), then one cycle (STORE) in which the
//   parallel word is presented with a valid strobe.
//
// Ports
//   iCLK          system clock; all logic runs on its rising edge
//   iRST          asynchronous reset, active low
//   iEN           enable; low aborts a readout in progress
//   iSTART        single-cycle readout request, honoured only when idle
//   iADC_CLK_DIV  SCLK half-period in iCLK cycles; latched at start (0 means 1)
//   iSDATA        serial data, one bit per ADC
//   oCS_n         ADC chip select, active low
//   oSCLK         ADC serial clock
//   oDATA         parallel samples, ADC k in bits [k*W+W-1 : k*W]
//   oDATA_VALID   one-cycle strobe, oDATA holds a new sample set
//   oBUSY         readout in progress
//   oDONE         one-cycle strobe, readout complete
module adc_deser #(
    parameter int ADC_DATA_WIDTH  = 16,
    parameter int TOTAL_ADCS      = 10,
    parameter int FE_CLOCK_CYCLES = 64
) (
    input  logic                                 iCLK,
    input  logic                                 iRST,
    input  logic                                 iEN,
    input  logic                                 iSTART,
    input  logic [15:0]                          iADC_CLK_DIV,
    input  logic [TOTAL_ADCS-1:0]                iSDATA,
    output logic                                 oCS_n,
    output logic                                 oSCLK,
    output logic [TOTAL_ADCS*ADC_DATA_WIDTH-1:0] oDATA,
    output logic                                 oDATA_VALID,
    output logic                                 oBUSY,
    output logic                                 oDONE
);

    localparam int DW     = TOTAL_ADCS * ADC_DATA_WIDTH;
    localparam int CNT_W  = $clog2(FE_CLOCK_CYCLES + 1);
    localparam int HALF_W = $clog2(2 * ADC_DATA_WIDTH);

    localparam logic [CNT_W-1:0]  SAMPLES_LAST = CNT_W'(FE_CLOCK_CYCLES);
    localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(2 * ADC_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [15:0]         div_q;       // latched SCLK half-period, never 0
    logic [15:0]         tick_q;      // iCLK cycles within the current SCLK half-period
    logic [HALF_W-1:0]   half_q;      // SCLK half-period index within SHIFT
    logic [CNT_W-1:0]    sample_q;    // samples stored in this readout
    logic [DW-1:0]       shreg_q;
    logic [DW-1:0]       shreg_d;
    logic [DW-1:0]       data_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    // Every ADC shift register takes its own serial bit in at the LSB.
    always_comb begin
        shreg_d = shreg_q;
        for (int k = 0; k < TOTAL_ADCS; k++) begin
            shreg_d[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] =
                {shreg_q[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH-1], iSDATA[k]};
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= S_IDLE;
            div_q    <= 16'd1;
            tick_q   <= '0;
            half_q   <= '0;
            sample_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE && !iEN) begin
                // Abort: release the ADCs and keep the last stored word.
                state_q <= S_IDLE;
                cs_n_q  <= 1'b1;
                sclk_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (iSTART && iEN) begin
                            state_q  <= S_CONV;
                            cs_n_q   <= 1'b0;
                            busy_q   <= 1'b1;
                            sample_q <= '0;
                            div_q    <= (iADC_CLK_DIV == 16'd0) ? 16'd1 : iADC_CLK_DIV;
                        end
                    end
                    S_CONV: begin
                        state_q <= S_SHIFT;
                        tick_q  <= '0;
                        half_q  <= '0;
                        sclk_q  <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (tick_q == div_q - 16'd1) begin
                            tick_q <= '0;
                            if (half_q == HALF_LAST) begin
                                // The final half-period was high, so SCLK
                                // falls as the word is presented.
                                state_q  <= S_STORE;
                                sclk_q   <= 1'b0;
                                cs_n_q   <= 1'b1;
                                data_q   <= shreg_q;
                                valid_q  <= 1'b1;
                                sample_q <= sample_q + CNT_W'(1);
                            end else begin
                                half_q <= half_q + HALF_W'(1);
                                sclk_q <= ~sclk_q;
                                // Capture on the edge that raises SCLK.
                                if (!sclk_q) begin
                                    shreg_q <= shreg_d;
                                end
                            end
                        end else begin
                            tick_q <= tick_q + 16'd1;
                        end
                    end
                    S_STORE: begin
                        if (sample_q == SAMPLES_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CONV;
                            cs_n_q  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oCS_n       = cs_n_q;
    assign oSCLK       = sclk_q;
    assign oDATA       = data_q;
    assign oDATA_VALID = valid_q;
    assign oBUSY       = busy_q;
    assign oDONE       = done_q;

endmodule

// File: tb/tb_adc_deser.sv
// Testbench for adc_deser: W=16, two ADCs, three samples per readout.
module tb_adc_deser;

    localparam int W   = 16;
    localparam int NA  = 2;
    localparam int FE  = 3;
    localparam int DW  = W * NA;

    logic          iCLK;
    logic          iRST;
    logic          iEN;
    logic          iSTART;
    logic [15:0]   iADC_CLK_DIV;
    logic [NA-1:0] iSDATA;
    logic          oCS_n;
    logic          oSCLK;
    logic [DW-1:0] oDATA;
    logic          oDATA_VALID;
    logic          oBUSY;
    logic          oDONE;

    adc_deser #(
        .ADC_DATA_WIDTH (W),
        .TOTAL_ADCS     (NA),
        .FE_CLOCK_CYCLES(FE)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iEN         (iEN),
        .iSTART      (iSTART),
        .iADC_CLK_DIV(iADC_CLK_DIV),
        .iSDATA      (iSDATA),
        .oCS_n       (oCS_n),
        .oSCLK       (oSCLK),
        .oDATA       (oDATA),
        .oDATA_VALID (oDATA_VALID),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- ADC model ----------------
    // Each ADC presents its MSB when chip select falls and the next bit after
    // every SCLK falling edge. Each conversion gets a fresh word, which is
    // also queued as the expected parallel result.
    bit             use_fixed = 1'b0;
    logic [DW-1:0]  fixed_word = 32'h1234A5C3;
    logic [DW-1:0]  adc_word = '0;
    int             bit_idx = 0;
    logic [DW-1:0]  exp_q[$];

    always @(negedge oCS_n) begin
        if (use_fixed) begin
            adc_word = fixed_word;
        end else begin
            for (int k = 0; k < NA; k++) adc_word[k*W +: W] = W'($urandom);
        end
        bit_idx = 0;
        exp_q.push_back(adc_word);
    end

    always @(negedge oSCLK) begin
        if (!oCS_n) bit_idx = bit_idx + 1;
    end

    always_comb begin
        iSDATA = '0;
        for (int k = 0; k < NA; k++) begin
            if (bit_idx < W) iSDATA[k] = adc_word[k*W + (W - 1 - bit_idx)];
        end
    end

    // ---------------- observation ----------------
    int            vld_cyc[$];
    logic [DW-1:0] vld_dat[$];
    int            done_cyc[$];
    int            sclk_rise[$];
    int            cs_runs[$];
    int            cs_low_run = 0;
    logic          sclk_prev  = 1'b0;

    always @(negedge iCLK) begin
        if (!oCS_n) begin
            cs_low_run = cs_low_run + 1;
        end else if (cs_low_run != 0) begin
            cs_runs.push_back(cs_low_run);
            cs_low_run = 0;
        end
        if (oSCLK && !sclk_prev) sclk_rise.push_back(cyc);
        sclk_prev = oSCLK;
        if (oDATA_VALID) begin
            vld_cyc.push_back(cyc);
            vld_dat.push_back(oDATA);
        end
        if (oDONE) done_cyc.push_back(cyc);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_obs();
        vld_cyc.delete();
        vld_dat.delete();
        done_cyc.delete();
        sclk_rise.delete();
        cs_runs.delete();
        exp_q.delete();
    endtask

    task automatic start_readout(input logic [15:0] div, output int c);
        @(negedge iCLK);
        clear_obs();
        iADC_CLK_DIV = div;
        iSTART = 1'b1;
        c = cyc;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (oBUSY && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        chk("idle_within_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 5000) begin
            @(negedge iCLK);
            n++;
        end
        chk("reach_cycle", 64'(cyc), 64'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"},  64'(oCS_n), 64'd1);
        chk({tag, "_sclk"},  64'(oSCLK), 64'd0);
        chk({tag, "_data"},  64'(oDATA), 64'd0);
        chk({tag, "_valid"}, 64'(oDATA_VALID), 64'd0);
        chk({tag, "_busy"},  64'(oBUSY), 64'd0);
        chk({tag, "_done"},  64'(oDONE), 64'd0);
    endtask

    // Reference timing: with start accepted on the edge after cycle c and
    // per-sample period P = 2 + 2*d*W, sample i (0-based) is stored at cycle
    // c + (i+1)*P; its SCLK rises at c + i*P + 2 + d + 2*d*b; chip select is
    // low for 1 + 2*d*W cycles; DONE follows the last store by one cycle.
    task automatic check_readout(input int d, input int c, input int nv, input bit exp_done);
        int p;
        p = 2 + 2 * d * W;
        chk("valid_count", 64'(vld_cyc.size()), 64'(nv));
        for (int i = 0; i < nv && i < vld_cyc.size(); i++) begin
            chk("valid_cycle", 64'(vld_cyc[i]), 64'(c + (i + 1) * p));
            if (i < exp_q.size()) chk("valid_data", 64'(vld_dat[i]), 64'(exp_q[i]));
        end
        chk("done_count", 64'(done_cyc.size()), exp_done ? 64'd1 : 64'd0);
        if (exp_done && done_cyc.size() > 0)
            chk("done_cycle", 64'(done_cyc[0]), 64'(c + FE * p + 1));
        if (exp_done) chk("sclk_rise_count", 64'(sclk_rise.size()), 64'(FE * W));
        for (int i = 0; i < nv; i++) begin
            for (int b = 0; b < W; b++) begin
                if (i * W + b < sclk_rise.size())
                    chk("sclk_rise_cycle", 64'(sclk_rise[i*W + b]), 64'(c + i * p + 2 + d + 2 * d * b));
            end
            if (i < cs_runs.size()) chk("cs_low_length", 64'(cs_runs[i]), 64'(1 + 2 * d * W));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        int n;
        iRST = 1'b1;
        iEN = 1'b0;
        iSTART = 1'b0;
        iADC_CLK_DIV = 16'd2;
        #2 iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_reset_outputs("reset");
        iRST = 1'b1;
        iEN = 1'b1;
        repeat (2) @(negedge iCLK);
        chk("idle_busy", 64'(oBUSY), 64'd0);

        // Fixed pattern, div 2: three stores 66 cycles apart.
        use_fixed = 1'b1;
        start_readout(16'd2, c);
        chk("conv_busy", 64'(oBUSY), 64'd1);
        chk("conv_cs_n", 64'(oCS_n), 64'd0);
        wait_idle(2000);
        check_readout(2, c, FE, 1'b1);
        if (vld_dat.size() > 0) chk("fixed_word", 64'(vld_dat[0]), 64'h1234A5C3);
        use_fixed = 1'b0;

        // Random data at div 1 and 3.
        start_readout(16'd1, c);
        wait_idle(2000);
        check_readout(1, c, FE, 1'b1);
        start_readout(16'd3, c);
        wait_idle(2000);
        check_readout(3, c, FE, 1'b1);

        // div 0 must behave exactly like div 1.
        start_readout(16'd0, c);
        wait_idle(2000);
        check_readout(1, c, FE, 1'b1);

        // iSTART held high throughout: one readout, one DONE.
        @(negedge iCLK);
        clear_obs();
        iADC_CLK_DIV = 16'd2;
        iSTART = 1'b1;
        c = cyc;
        n = 0;
        while (!oDONE && n < 2000) begin
            @(negedge iCLK);
            n++;
        end
        iSTART = 1'b0;
        chk("start_hold_done_seen", 64'(n < 2000), 64'd1);
        wait_idle(10);
        repeat (5) @(negedge iCLK);
        chk("start_hold_stays_idle", 64'(oBUSY), 64'd0);
        check_readout(2, c, FE, 1'b1);

        // iEN dropped in the 10th SHIFT cycle of the second sample.
        start_readout(16'd2, c);
        wait_cyc(c + (2 + 4 * W) + 11);
        iEN = 1'b0;
        @(negedge iCLK);
        chk("abort_cs_n", 64'(oCS_n), 64'd1);
        chk("abort_busy", 64'(oBUSY), 64'd0);
        chk("abort_sclk", 64'(oSCLK), 64'd0);
        repeat (20) @(negedge iCLK);
        check_readout(2, c, 1, 1'b0);
        if (exp_q.size() > 0) chk("abort_data_held", 64'(oDATA), 64'(exp_q[0]));
        iEN = 1'b1;

        // Asynchronous reset in the middle of SHIFT, then a clean readout.
        start_readout(16'd2, c);
        wait_cyc(c + 20);
        #1 iRST = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge iCLK);
        iRST = 1'b1;
        start_readout(16'd2, c);
        wait_idle(2000);
        check_readout(2, c, FE, 1'b1);

        // Divider changed mid-readout: current readout keeps div 2.
        start_readout(16'd2, c);
        repeat (30) @(negedge iCLK);
        iADC_CLK_DIV = 16'd5;
        wait_idle(2000);
        check_readout(2, c, FE, 1'b1);
        start_readout(16'd5, c);
        wait_idle(2000);
        check_readout(5, c, FE, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
